// File: rtl/ex_muldiv_ctrl.sv
// ex_muldiv_ctrl: sequencer for the shared iterative RV32M multiply/divide unit.
// It runs one shift-add or restoring-divide step per cycle, applies the sign
// fix-up on the last step, and presents the result with a one-cycle done pulse.
//
// Handshake: an op is accepted on a rising edge where the FSM is IDLE, start=1
// and flush=0. stall is raised combinationally in that same cycle and stays high
// through CALC. done=1 marks result as valid for exactly one cycle, and result
// then holds until a later op completes. flush aborts in any state. A start seen
// outside IDLE is ignored.
module ex_muldiv_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rdata1,
    input  logic [XLEN-1:0] rdata2,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   count;
    logic [2:0]      op;
    logic            neg_q;   // s1^s2: negate the product or quotient
    logic            neg_r;   // s1: negate the remainder
    logic [XLEN-1:0] hi;      // product high half, or partial remainder
    logic [XLEN-1:0] lo;      // multiplier bits, or dividend/quotient bits
    logic [XLEN-1:0] mag_b;   // multiplicand or divisor magnitude

    // Decoding of the incoming op, evaluated in the accept cycle
    logic            s1_in, s2_in, accept, div_zero, div_ovf, special;
    logic [XLEN-1:0] mag1_in, mag2_in, special_res;

    assign accept   = (state == IDLE) && start && !flush;
    assign s1_in    = rdata1[XLEN-1] && (funct3 == 3'd1 || funct3 == 3'd2 ||
                                         funct3 == 3'd4 || funct3 == 3'd6);
    assign s2_in    = rdata2[XLEN-1] && (funct3 == 3'd1 || funct3 == 3'd4 ||
                                         funct3 == 3'd6);
    assign mag1_in  = s1_in ? -rdata1 : rdata1;
    assign mag2_in  = s2_in ? -rdata2 : rdata2;
    assign div_zero = funct3[2] && (rdata2 == '0);
    assign div_ovf  = (funct3 == 3'd4 || funct3 == 3'd6) &&
                      (rdata1 == {1'b1, {(XLEN-1){1'b0}}}) && (rdata2 == '1);
    assign special  = div_zero || div_ovf;

    // Special divides resolve at accept; funct3[1] selects the remainder form
    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = funct3[1] ? rdata1 : '1;
        else if (div_ovf)
            special_res = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    // One iteration step for the multiply or the divide, plus the final fix-up
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN+1:0]   div_diff;
    logic [XLEN-1:0]   step_hi, step_lo, quot_s, rem_s, final_res;
    logic [2*XLEN-1:0] prod_s;

    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, mag_b} : '0);
        div_shift = {hi, lo[XLEN-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, mag_b};
        if (op[2]) begin
            step_hi = div_diff[XLEN+1] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
            step_lo = {lo[XLEN-2:0], ~div_diff[XLEN+1]};
        end else begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], lo[XLEN-1:1]};
        end
        prod_s = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
        quot_s = neg_q ? -step_lo : step_lo;
        rem_s  = neg_r ? -step_hi : step_hi;
        case (op)
            3'd0:                final_res = prod_s[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    final_res = prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5:          final_res = quot_s;
            default:             final_res = rem_s;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic; flush overrides everything
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = special ? DONE : CALC;
            CALC:    if (count == LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    // Operand latch, iteration datapath, counter and result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            op     <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            mag_b  <= '0;
            result <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (accept) begin
            count <= '0;
            op    <= funct3;
            neg_q <= s1_in ^ s2_in;
            neg_r <= s1_in;
            hi    <= '0;
            lo    <= mag1_in;
            mag_b <= mag2_in;
            if (special) result <= special_res;
        end else if (state == CALC) begin
            hi    <= step_hi;
            lo    <= step_lo;
            count <= (count == LAST) ? '0 : count + 1'b1;
            if (count == LAST) result <= final_res;
        end
    end

    assign stall = accept || (state == CALC);
    assign busy  = (state != IDLE);
    assign done  = (state == DONE);

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// tb_ex_muldiv_ctrl: directed and random RV32M ops against a reference model,
// plus the flush, held-start and reset scenarios.
module tb_ex_muldiv_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] rdata1 = '0;
    logic [31:0] rdata2 = '0;
    logic        flush = 1'b0;
    logic        stall, busy, done;
    logic [31:0] result;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_res = '0;

    ex_muldiv_ctrl #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3),
        .rdata1(rdata1), .rdata2(rdata2), .flush(flush),
        .stall(stall), .busy(busy), .done(done), .result(result)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model of the RV32M result
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        logic [63:0] p;
        logic ovf;
        sa = a;
        sb = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
            3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return sa / sb;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return sa % sb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && b == 0) return 1;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Drive one op, wait for done with a cycle budget, check latency, stall and result
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int n;
        int stall_cnt;
        int lat;
        logic [31:0] want;
        lat = latency(f, a, b);
        @(negedge clk);
        start = 1'b1; funct3 = f; rdata1 = a; rdata2 = b;
        exp_q.push_back(exp);
        #1 check({tag, "_stall_accept"}, {31'b0, stall}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n = 1;
        stall_cnt = 0;
        while (!done && n < 40) begin
            stall_cnt += int'(stall);
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, {31'b0, done}, 32'd1);
        check({tag, "_latency"}, n, lat);
        check({tag, "_stall_cycles"}, stall_cnt, lat - 1);
        check({tag, "_stall_in_done"}, {31'b0, stall}, 32'd0);
        want = exp_q.pop_front();
        check({tag, "_result"}, result, want);
        last_res = want;
        @(negedge clk);
        check({tag, "_done_pulse"}, {30'b0, done, busy}, 32'd0);
    endtask

    initial begin
        int dones;
        logic [2:0] rf;
        logic [31:0] ra, rb;

        // Reset state
        #2;
        check("reset_outputs", {29'b0, stall, busy, done}, 32'd0);
        check("reset_result", result, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Multiply
        run_op("mul_7_m3",   3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run_op("mulhu_ff",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("mulh_ff",    3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        run_op("mulhsu_m1_2", 3'd2, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF);

        // Divide
        run_op("div_m7_2",   3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_op("rem_m7_2",   3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_op("divu_100_7", 3'd5, 32'd100,       32'd7, 32'd14);
        run_op("remu_100_7", 3'd7, 32'd100,       32'd7, 32'd2);

        // Special divides
        run_op("div_5_0",    3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF);
        run_op("remu_5_0",   3'd7, 32'd5,         32'd0,         32'd5);
        run_op("div_ovf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem_ovf",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);

        // Random ops against the model
        for (int i = 0; i < 10; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            run_op("rand", rf, ra, rb, model(rf, ra, rb));
        end

        // Flush at CALC iteration 10
        @(negedge clk);
        start = 1'b1; funct3 = 3'd0; rdata1 = 32'd7; rdata2 = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        check("flush_idle", {29'b0, stall, busy, done}, 32'd0);
        check("flush_result_held", result, last_res);
        dones = 0;
        repeat (36) begin
            @(negedge clk);
            dones += int'(done);
        end
        check("flush_no_done", dones, 0);
        run_op("after_flush", 3'd0, 32'd6, 32'd9, 32'd54);

        // start held continuously: second accept only after DONE plus an IDLE cycle
        @(negedge clk);
        start = 1'b1; funct3 = 3'd5; rdata1 = 32'd100; rdata2 = 32'd7;
        exp_q.push_back(32'd14);
        exp_q.push_back(32'd14);
        dones = 0;
        while (!done && dones < 40) begin
            @(negedge clk);
            dones++;
        end
        check("held_first_done", {31'b0, done}, 32'd1);
        check("held_first_result", result, exp_q.pop_front());
        check("held_stall_in_done", {31'b0, stall}, 32'd0);
        @(negedge clk);
        check("held_idle_gap", {30'b0, busy, stall}, 32'd1);
        @(negedge clk);
        check("held_second_accept", {31'b0, busy}, 32'd1);
        start = 1'b0;
        dones = 0;
        while (!done && dones < 40) begin
            @(negedge clk);
            dones++;
        end
        check("held_second_done", {31'b0, done}, 32'd1);
        check("held_second_result", result, exp_q.pop_front());

        // Reset mid-CALC: outputs clear asynchronously, no done afterwards
        @(negedge clk);
        start = 1'b1; funct3 = 3'd0; rdata1 = 32'd3; rdata2 = 32'd5;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_outputs", {29'b0, stall, busy, done}, 32'd0);
        check("rst_mid_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (36) begin
            @(negedge clk);
            dones += int'(done);
        end
        check("rst_no_done", dones, 0);

        // start and flush together in IDLE: not accepted
        @(negedge clk);
        start = 1'b1; flush = 1'b1; funct3 = 3'd0; rdata1 = 32'd2; rdata2 = 32'd2;
        #1 check("start_flush_stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        check("start_flush_busy", {31'b0, busy}, 32'd0);
        start = 1'b0; flush = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ex_muldiv_ctrl.md
Name: ex_muldiv_ctrl

Overview:
- Sequencer for a shared iterative multiply/divide unit in the execute stage, implementing the RV32M operations.
- Accepts one operation from execute and holds the pipeline via `stall` while it iterates. Presents the result with a one-cycle `done` pulse, which the execute result mux selects in place of the ALU result.
- Contains the FSM, the iteration counter, the operand/accumulator registers and the sign fix-up.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported. Counter width is clog2(XLEN)+1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; decoded M-extension op valid in execute.
- funct3  input  3  op select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rdata1  input  32  operand rs1.
- rdata2  input  32  operand rs2.
- flush  input  1  pipeline flush (taken branch/jump); aborts the operation.
- stall  output  1  holds the upstream pipeline.
- busy  output  1  the FSM is not IDLE.
- done  output  1  one-cycle pulse; result valid.
- result  output  32  operation result; held until the next accept.

Behaviour:
- Reset values: state IDLE, counter 0, result 0; done, busy and stall 0.
- States: IDLE, CALC, DONE.
- Accept: in IDLE with start=1 and flush=0. Operands, funct3 and sign flags are latched on that edge.
- After accept, the next state is CALC. The exception is the special divides, which go straight to DONE.
- Sign handling:
  - s1 = rdata1[31] for MULH, MULHSU, DIV and REM; otherwise 0.
  - s2 = rdata2[31] for MULH, DIV and REM; otherwise 0.
  - Magnitudes are latched as |op| when the sign flag is set, else the raw value.
- Multiply in CALC: one shift-add step per cycle over 32 cycles on the unsigned magnitudes, producing a 64-bit product.
  - The product is negated if s1^s2.
  - MUL returns bits [31:0]; MULH, MULHSU and MULHU return bits [63:32].
- Divide in CALC: restoring division, one quotient bit per cycle over 32 cycles.
  - The quotient is negated if s1^s2; the remainder is negated if s1.
  - DIV and DIVU return the quotient; REM and REMU return the remainder.
- Counter: runs 0..31 in CALC. When count=31, the next state is DONE and result is registered on that edge.
- Special divides are resolved at accept and go directly to DONE:
  - Divide by zero: quotient 0xFFFFFFFF, remainder = rdata1.
  - Signed overflow (0x80000000 / 0xFFFFFFFF for DIV/REM): quotient 0x80000000, remainder 0.
- Timing:
  - Normal ops: accept at edge T, done=1 during cycle T+33, so 33-cycle latency.
  - Special divides: done=1 during cycle T+1.
- DONE: done=1 for exactly one cycle, then IDLE. A start seen in DONE is ignored; the pipeline advances past the op during DONE.
- stall (combinational) = (state==IDLE & start & ~flush) | state==CALC. It is 0 in DONE.
- busy = state!=IDLE.
- Flush:
  - In any state, the next state is IDLE, the counter is cleared, done stays 0 and result keeps its previous value.
  - flush has priority over start in the same cycle.
  - A flush during DONE still leaves done=1 that cycle; the consumer qualifies done with its own flush.
- start while in CALC: ignored, with no re-latch.
- Reset mid-operation: immediate return to the reset values, and no done is produced.

Test Plan:
- MUL 7 × -3 (rdata2=0xFFFFFFFD), funct3=0 -> stall high for 33 cycles, done at T+33, result=0xFFFFFFEB.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF -> result=0xFFFFFFFE. MULH with the same operands -> 0x00000000. MULHSU with rs1=0xFFFFFFFF, rs2=2 -> 0xFFFFFFFF.
- Signed DIV/REM with -7 (0xFFFFFFF9) and 2:
  - DIV -7 / 2 -> 0xFFFFFFFD.
  - REM -7 % 2 -> 0xFFFFFFFF.
  - DIVU 100 / 7 -> 14.
  - REMU 100 % 7 -> 2.
- Special cases:
  - DIV 5 / 0 -> done at T+1, result 0xFFFFFFFF.
  - REMU 5 % 0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - REM with the same operands -> 0.
- Flush at CALC iteration 10 -> IDLE next cycle, no done pulse, result unchanged. A new start the following cycle completes normally.
- Back-to-back and reset:
  - start held continuously -> second op accepted only after DONE, with a gap of at least one IDLE cycle.
  - rst asserted mid-CALC -> all outputs 0 asynchronously.
  - start and flush together in IDLE -> not accepted, stall 0.
